phv_writeback: RTL and testbench
================================

// Module: phv_writeback
// PURPOSE
//  Downstream neighbour of the per-container ALUs in each RMT action stage. Holds each PHV for exactly
//  ALU_LATENCY cycles while the ALUs compute, merges every valid ALU container result into its slot,
//  and buffers merged PHVs in a small FIFO with valid/ready toward the next stage's parser/key extractor.
// PARAMETERS
//  STAGE        0    stage index (debug/statistics tagging only)
//  DATA_WIDTH   48   container width, equals the ALU data width
//  NUM_LANES    8    ALU lanes; lane i owns PHV bits [i*DATA_WIDTH +: DATA_WIDTH]
//  PHV_LEN      640  total PHV width, >= NUM_LANES*DATA_WIDTH; bits above the containers are metadata, passed unchanged
//  ALU_LATENCY  3    cycles from action_valid at ALU input to container_out_valid
//  FIFO_DEPTH   8    output FIFO entries, power of 2, > ALU_LATENCY
// PORTS
//  clk                 in   1                     stage clock
//  rst_n               in   1                     reset, synchronous, active-low
//  phv_in              in   PHV_LEN               PHV, issued in the same cycle as the ALU actions
//  phv_in_valid        in   1                     phv_in qualifier
//  phv_in_ready        out  1                     upstream may issue a PHV/action this cycle
//  container_in        in   NUM_LANES*DATA_WIDTH  flattened ALU container_out buses
//  container_in_valid  in   NUM_LANES             per-lane container_out_valid
//  phv_out             out  PHV_LEN               merged PHV
//  phv_out_valid       out  1                     FIFO head valid
//  phv_out_ready       in   1                     downstream accepts when valid&ready
//  orphan_err          out  1                     sticky: lane result arrived with no PHV at the merge point
// BEHAVIOUR
//  - Reset (rst_n low at posedge): FIFO empty, delay line cleared, phv_out_valid=0, phv_out=0,
//    phv_in_ready=1, orphan_err=0. A mid-operation reset discards in-flight and buffered PHVs.
//  - Accept = phv_in_valid & phv_in_ready. An accepted PHV enters an ALU_LATENCY-deep valid-tagged
//    shift register; the line always advances (the ALUs cannot stall), so the PHV reaches the merge
//    point in the same cycle as its lane results.
//  - Merge (combinational at the delay-line output): lane i with container_in_valid[i]=1 replaces its slot;
//    lanes with valid=0 keep the original bits; metadata is never modified. The merged PHV is written to the FIFO.
//  - Lane valid high while the delay-line output tag is 0: result dropped, orphan_err set until reset.
//  - FIFO: registered head. The first PHV into an empty FIFO gives phv_out_valid ALU_LATENCY+1 cycles
//    after accept. Pop = phv_out_valid & phv_out_ready. Simultaneous push and pop at any
//    occupancy, including full, is legal; occupancy stays unchanged.
//  - Credit rule: phv_in_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight = number of set tags
//    in the delay line. The FIFO therefore never overflows; a push into a full FIFO is impossible by
//    construction (assertion). Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
//  - phv_out and phv_out_valid hold stable while valid & !ready.
// CONFIGURATION
//  PHV_WB_STATS_EN defined: adds outputs stat_phv_cnt[31:0] (merged PHVs popped) and stat_orphan_cnt[15:0]
//    (orphan lane events, saturating). Both reset to 0, and stat_phv_cnt wraps. Without the macro these
//    ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package rmt_pkg: DATA_WIDTH, NUM_LANES, PHV_LEN constants; container_t (logic [DATA_WIDTH-1:0]);
//    function lane_lo(i) = i*DATA_WIDTH.
//  - Sub-module phv_wb_fifo (generic sync FIFO: width, depth, count output, registered head).
//    The delay line, merge, and credit logic stay in the top level.
// TESTING
//  1 Single PHV, no backpressure: phv_in all 0 except metadata 0xAB; lanes 0 and 3 return 0x1 and
//    0xFFFF_FFFF_FFFF at +3 -> at +4 phv_out has exactly those slots, other slots 0, metadata 0xAB.
//  2 No lane valid -> phv_out bit-identical to phv_in.
//  3 Back-to-back PHVs with phv_out_ready=0: at most 8 accepted (phv_in_ready falls when count+inflight=8),
//    no loss; after ready=1, 8 pops in order.
//  4 FIFO full with push and pop in the same cycle: count stays 8, order preserved, no drop.
//  5 Lane 5 valid with no PHV issued 3 cycles earlier -> orphan_err=1 and stays set. With
//    PHV_WB_STATS_EN, stat_orphan_cnt=1.
//  6 rst_n low for 1 cycle with 3 PHVs in flight and 2 buffered -> next cycle phv_out_valid=0,
//    phv_in_ready=1, and nothing emerges afterwards.

Source files
------------

// File: rtl/rmt_pkg.sv
// Shared RMT stage constants: container geometry and the lane-to-PHV-slot mapping.
package rmt_pkg;

  localparam int DATA_WIDTH = 48;
  localparam int NUM_LANES  = 8;
  localparam int PHV_LEN    = 640;

  typedef logic [DATA_WIDTH-1:0] container_t;

  function automatic int lane_lo(input int i);
    return i * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/phv_wb_chk.sv
// Protocol checker for the writeback FIFO: no push into a full FIFO, occupancy never exceeds depth.
module phv_wb_chk #(
  parameter int STAGE = 0,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(DEPTH))))
    else $error("phv_writeback stage %0d: push into full FIFO", STAGE);

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH))
    else $error("phv_writeback stage %0d: FIFO count out of range", STAGE);

endmodule

// File: rtl/phv_wb_fifo.sv
// Generic synchronous FIFO with a registered head, occupancy count, and push+pop at any occupancy.
module phv_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  logic             pop_s;
  logic             wr_en_s;
  logic [CNT_W-1:0] count_next_s;

  assign pop_s   = valid_r & dout_ready;
  // A full FIFO only takes a write when the head leaves in the same cycle.
  assign wr_en_s = push & ((count_r != CNT_W'(DEPTH)) | pop_s);

  // Next occupancy from the write/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage, pointers and head-valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != CNT_W'(0));
    end
  end

  assign dout       = mem_r[rd_ptr_r];
  assign dout_valid = valid_r;
  assign count      = count_r;

endmodule

// File: rtl/phv_writeback.sv
// RMT action-stage writeback: delays each PHV by the ALU latency, merges lane results, buffers in a FIFO.
// Optional feature macro PHV_WB_STATS_EN adds stat_phv_cnt / stat_orphan_cnt counters.
module phv_writeback #(
  parameter int STAGE       = 0,
  parameter int DATA_WIDTH  = rmt_pkg::DATA_WIDTH,
  parameter int NUM_LANES   = rmt_pkg::NUM_LANES,
  parameter int PHV_LEN     = rmt_pkg::PHV_LEN,
  parameter int ALU_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_in_valid,
  output logic                            phv_in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] container_in,
  input  logic [NUM_LANES-1:0]            container_in_valid,
  output logic [PHV_LEN-1:0]              phv_out,
  output logic                            phv_out_valid,
  input  logic                            phv_out_ready,
  output logic                            orphan_err
`ifdef PHV_WB_STATS_EN
  ,
  output logic [31:0]                     stat_phv_cnt,
  output logic [15:0]                     stat_orphan_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [PHV_LEN-1:0]     dl_data_r [ALU_LATENCY];
  logic [ALU_LATENCY-1:0] dl_tag_r;
  logic                   accept_s;
  logic                   tail_tag_s;
  logic [PHV_LEN-1:0]     tail_data_s;
  logic [PHV_LEN-1:0]     merged_s;
  logic                   orphan_s;
  logic [CNT_W-1:0]       inflight_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic                   orphan_err_r;

  assign accept_s    = phv_in_valid & phv_in_ready;
  assign tail_tag_s  = dl_tag_r[ALU_LATENCY-1];
  assign tail_data_s = dl_data_r[ALU_LATENCY-1];

  // Free-running delay line: the ALUs never stall, so neither does this.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_tag_r <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) begin
        dl_data_r[i] <= '0;
      end
    end else begin
      dl_tag_r[0]  <= accept_s;
      dl_data_r[0] <= phv_in;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        dl_tag_r[i]  <= dl_tag_r[i-1];
        dl_data_r[i] <= dl_data_r[i-1];
      end
    end
  end

  // Lane merge; metadata above the container slots passes through untouched.
  always_comb begin
    merged_s = tail_data_s;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (container_in_valid[i]) begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = container_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = tail_data_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // In-flight PHVs already hold a FIFO slot, which is what keeps the FIFO from overflowing.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < ALU_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_W'(dl_tag_r[i]);
    end
  end

  assign phv_in_ready = (SUM_W'(fifo_count_s) + SUM_W'(inflight_s)) < SUM_W'(FIFO_DEPTH);
  assign orphan_s     = ~tail_tag_s & (|container_in_valid);

  // Sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orphan_err_r <= 1'b0;
    end else if (orphan_s) begin
      orphan_err_r <= 1'b1;
    end
  end

  assign orphan_err = orphan_err_r;

  phv_wb_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (tail_tag_s),
    .din        (merged_s),
    .dout_ready (phv_out_ready),
    .dout       (phv_out),
    .dout_valid (phv_out_valid),
    .count      (fifo_count_s)
  );

  phv_wb_chk #(
    .STAGE (STAGE),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail_tag_s),
    .pop   (phv_out_valid & phv_out_ready),
    .count (fifo_count_s)
  );

`ifdef PHV_WB_STATS_EN
  logic [31:0] stat_phv_cnt_r;
  logic [15:0] stat_orphan_cnt_r;

  // Popped-PHV counter wraps; orphan counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_phv_cnt_r    <= 32'd0;
      stat_orphan_cnt_r <= 16'd0;
    end else begin
      if (phv_out_valid & phv_out_ready) begin
        stat_phv_cnt_r <= stat_phv_cnt_r + 32'd1;
      end
      if (orphan_s && (stat_orphan_cnt_r != 16'hFFFF)) begin
        stat_orphan_cnt_r <= stat_orphan_cnt_r + 16'd1;
      end
    end
  end

  assign stat_phv_cnt    = stat_phv_cnt_r;
  assign stat_orphan_cnt = stat_orphan_cnt_r;
`endif

endmodule

// File: tb/tb_phv_writeback.sv
// Bench for phv_writeback: directed merge vectors, queue-model random traffic, fill/drain, orphan, reset.
module tb_phv_writeback;
  import rmt_pkg::*;

  localparam int PL = 640;
  localparam int CW = 384;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PL-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_in_ready;
  logic [CW-1:0] container_in;
  logic [7:0]    container_in_valid;
  logic [PL-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic          orphan_err;
`ifdef PHV_WB_STATS_EN
  logic [31:0]   stat_phv_cnt;
  logic [15:0]   stat_orphan_cnt;
`endif

  logic          f_push;
  logic [15:0]   f_din;
  logic          f_ready;
  logic [15:0]   f_dout;
  logic          f_valid;
  logic [3:0]    f_count;

  always #5 clk = ~clk;

  phv_writeback dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .phv_in             (phv_in),
    .phv_in_valid       (phv_in_valid),
    .phv_in_ready       (phv_in_ready),
    .container_in       (container_in),
    .container_in_valid (container_in_valid),
    .phv_out            (phv_out),
    .phv_out_valid      (phv_out_valid),
    .phv_out_ready      (phv_out_ready),
    .orphan_err         (orphan_err)
`ifdef PHV_WB_STATS_EN
    ,
    .stat_phv_cnt       (stat_phv_cnt),
    .stat_orphan_cnt    (stat_orphan_cnt)
`endif
  );

  phv_wb_fifo #(.WIDTH(16), .DEPTH(8)) u_sfifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (f_push),
    .din        (f_din),
    .dout_ready (f_ready),
    .dout       (f_dout),
    .dout_valid (f_valid),
    .count      (f_count)
  );

  int n_checks = 0;
  int n_err    = 0;
  int dut_acc  = 0;

  // Reference model: queue of merged PHVs plus a 3-deep accept history.
  logic [PL-1:0] mq[$];
  bit            ah[3];
  logic [PL-1:0] ph[3];
  logic [15:0]   fq[$];

  typedef struct {
    logic [PL-1:0] phv;
    logic [7:0]    lv;
    logic [CW-1:0] cont;
    logic [PL-1:0] exp;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [PL-1:0] got, input logic [PL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PL-1:0] rand_phv();
    logic [PL-1:0] r;
    for (int i = 0; i < PL/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [CW-1:0] rand_cont();
    logic [CW-1:0] r;
    for (int i = 0; i < CW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [PL-1:0] merge_ref(input logic [PL-1:0] base, input logic [7:0] lv,
                                              input logic [CW-1:0] cd);
    logic [PL-1:0] r;
    container_t    c;
    r = base;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = cd[lane_lo(i) +: DATA_WIDTH];
      if (lv[i]) r[lane_lo(i) +: DATA_WIDTH] = c;
    end
    return r;
  endfunction

  // One model-checked cycle: compare outputs, drive, clock, advance the model.
  task automatic step(input bit v, input bit r);
    logic [PL-1:0] p;
    logic [PL-1:0] mg;
    logic [CW-1:0] cd;
    logic [7:0]    lv;
    int            inflight;
    bit            exp_rdy;
    bit            acc;
    inflight = int'(ah[0]) + int'(ah[1]) + int'(ah[2]);
    exp_rdy  = (mq.size() + inflight) < 8;
    chk("in_ready", phv_in_ready, exp_rdy);
    chk("out_valid", phv_out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_data", phv_out, mq[0]);
    p  = rand_phv();
    cd = rand_cont();
    lv = ah[2] ? 8'($urandom) : 8'h00;
    phv_in             = p;
    phv_in_valid       = v;
    phv_out_ready      = r;
    container_in       = cd;
    container_in_valid = lv;
    acc = v & exp_rdy;
    if (v && phv_in_ready) dut_acc++;
    mg = merge_ref(ph[2], lv, cd);
    tick();
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (ah[2]) mq.push_back(mg);
    ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = acc;
    ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = p;
  endtask

  task automatic fstep(input bit push, input bit ready, input logic [15:0] din);
    chk("fifo_valid", f_valid, fq.size() > 0);
    chk("fifo_count", f_count, fq.size());
    if (fq.size() > 0) chk("fifo_head", f_dout, fq[0]);
    f_push  = push;
    f_ready = ready;
    f_din   = din;
    tick();
    if (ready && fq.size() > 0) void'(fq.pop_front());
    if (push) fq.push_back(din);
    f_push = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    phv_in        = v.phv;
    phv_in_valid  = 1'b1;
    phv_out_ready = 1'b1;
    tick();
    phv_in_valid = 1'b0;
    tick();
    tick();
    chk($sformatf("vec%0d_early_valid", idx), phv_out_valid, 1'b0);
    container_in       = v.cont;
    container_in_valid = v.lv;
    tick();
    container_in_valid = 8'h00;
    chk($sformatf("vec%0d_valid", idx), phv_out_valid, 1'b1);
    chk($sformatf("vec%0d_data", idx), phv_out, v.exp);
    tick();
    chk($sformatf("vec%0d_popped", idx), phv_out_valid, 1'b0);
  endtask

  initial begin
    logic [PL-1:0] e;
    int            a0;
    rst_n = 1'b0; phv_in = '0; phv_in_valid = 1'b0; phv_out_ready = 1'b0;
    container_in = '0; container_in_valid = 8'h00;
    f_push = 1'b0; f_din = 16'h0000; f_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin ah[i] = 1'b0; ph[i] = '0; end
    repeat (3) tick();
    chk("rst_out_valid", phv_out_valid, 1'b0);
    chk("rst_out_data", phv_out, '0);
    chk("rst_in_ready", phv_in_ready, 1'b1);
    chk("rst_orphan", orphan_err, 1'b0);
`ifdef PHV_WB_STATS_EN
    chk("rst_stat_phv", stat_phv_cnt, 32'd0);
    chk("rst_stat_orphan", stat_orphan_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Directed merge vectors.
    vecs[0].phv = '0;
    vecs[0].phv[384 +: 8] = 8'hAB;
    vecs[0].lv   = 8'b0000_1001;
    vecs[0].cont = rand_cont();
    vecs[0].cont[0 +: 48]   = 48'h1;
    vecs[0].cont[144 +: 48] = 48'hFFFF_FFFF_FFFF;
    e = '0;
    e[384 +: 8] = 8'hAB;
    e[0 +: 48]  = 48'h1;
    e[144 +: 48] = 48'hFFFF_FFFF_FFFF;
    vecs[0].exp = e;
    vecs[1].phv  = rand_phv();
    vecs[1].lv   = 8'h00;
    vecs[1].cont = rand_cont();
    vecs[1].exp  = vecs[1].phv;
    vecs[2].phv  = rand_phv();
    vecs[2].lv   = 8'hFF;
    vecs[2].cont = rand_cont();
    vecs[2].exp  = {vecs[2].phv[PL-1:CW], vecs[2].cont};
    vecs[3].phv  = rand_phv();
    vecs[3].lv   = 8'hA5;
    vecs[3].cont = rand_cont();
    vecs[3].exp  = merge_ref(vecs[3].phv, vecs[3].lv, vecs[3].cont);
    for (int i = 0; i < 4; i++) apply_vec(vecs[i], i);
    tick();

    // Random traffic against the model.
    repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    repeat (14) step(1'b0, 1'b1);

    // Back-to-back fill with backpressure, then stream at full, then drain.
    a0 = dut_acc;
    repeat (14) step(1'b1, 1'b0);
    chk("fill_accepts", dut_acc - a0, 8);
    repeat (20) step(1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1);
    phv_in_valid = 1'b0;

    // Standalone FIFO: simultaneous push and pop while full.
    for (int i = 0; i < 8; i++) fstep(1'b1, 1'b0, 16'(100 + i));
    for (int k = 0; k < 4; k++) begin
      fstep(1'b1, 1'b1, 16'(200 + k));
      chk("fifo_full_hold", f_count, 4'd8);
    end
    repeat (9) fstep(1'b0, 1'b1, 16'h0000);

    // Orphan lane result.
    chk("orphan_clear", orphan_err, 1'b0);
    container_in       = rand_cont();
    container_in_valid = 8'h20;
    tick();
    container_in_valid = 8'h00;
    chk("orphan_set", orphan_err, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    chk("orphan_sticky", orphan_err, 1'b1);
`ifdef PHV_WB_STATS_EN
    chk("stat_orphan", stat_orphan_cnt, 16'd1);
`endif

    // Reset with 3 PHVs in flight and 2 buffered.
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    phv_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", phv_out_valid, 1'b0);
    chk("mid_rst_in_ready", phv_in_ready, 1'b1);
    chk("mid_rst_orphan", orphan_err, 1'b0);
    chk("mid_rst_out_data", phv_out, '0);
    mq.delete();
    for (int i = 0; i < 3; i++) ah[i] = 1'b0;
    repeat (10) step(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
